my_fifo_reader: RTL and testbench

Dequeue-side reader for the block-RAM FIFO. It drains a first-word-fall-through FIFO read port and presents the words downstream as a valid/ready stream with packet framing (`o_last` every `PKT_LEN` words). A 2-entry skid buffer keeps `o_rden` free of any combinational path from `i_ready` while still sustaining one word per cycle.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_rd_skid.sv | 75 +++++++
 rtl/my_fifo_reader.sv | 70 +++++++
 tb/tb_my_fifo_reader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO dequeue-side reader.
// Occupancy encoding of the skid buffer and packet counter sizing.
package fifo_pkg;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    // Counter width for a packet of len words; never narrower than one bit.
    function automatic int pkt_cnt_w(input int len);
        return ($clog2(len) > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer between the FIFO read port and the output stream.
// state | meaning: EMPTY | no word held; ONE | entry0 valid; FULL | entry0 and entry1 valid
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output occ_t              level
);

    occ_t              occ, occ_nxt;
    logic [DATA_W-1:0] entry0, entry0_nxt;
    logic [DATA_W-1:0] entry1, entry1_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ    <= OCC_EMPTY;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            occ    <= occ_nxt;
            entry0 <= entry0_nxt;
            entry1 <= entry1_nxt;
        end
    end

    always_comb begin
        occ_nxt    = occ;
        entry0_nxt = entry0;
        entry1_nxt = entry1;
        if (flush) begin
            occ_nxt = OCC_EMPTY;
        end else begin
            unique case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        entry0_nxt = push_data;
                        occ_nxt    = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && !pop) begin
                        entry1_nxt = push_data;
                        occ_nxt    = OCC_FULL;
                    end else if (push && pop) begin
                        entry0_nxt = push_data;
                    end else if (pop) begin
                        occ_nxt = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // The top never pushes here, so only a drain can occur.
                    if (pop) begin
                        entry0_nxt = entry1;
                        occ_nxt    = OCC_ONE;
                    end
                end
                default: occ_nxt = OCC_EMPTY;
            endcase
        end
    end

    assign valid = (occ != OCC_EMPTY);
    assign data  = entry0;
    assign level = occ;

endmodule

// File: rtl/my_fifo_reader.sv
// Drains a first-word-fall-through FIFO into a framed valid/ready stream.
// The read enable is registered-only with respect to the downstream ready.
module my_fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PKT_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_rden,
    input  logic [DATA_W-1:0] i_rddata,
    input  logic              i_empty,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready,
    output logic [1:0]        o_level
);

    localparam int               CNT_W    = pkt_cnt_w(PKT_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_LEN - 1);

    logic             ready_rg;
    logic             hs;
    occ_t             level;
    logic [CNT_W-1:0] pkt_cnt, pkt_cnt_nxt;

    // Holds off the first pop until one full clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_rg <= 1'b0;
        else     ready_rg <= 1'b1;
    end

    assign o_rden = ready_rg & ~i_empty & (level < OCC_FULL) & ~i_flush;
    assign hs     = o_valid & i_ready;

    always_comb begin
        pkt_cnt_nxt = pkt_cnt;
        if (i_flush) begin
            pkt_cnt_nxt = '0;
        end else if (hs) begin
            pkt_cnt_nxt = (pkt_cnt == CNT_LAST) ? '0 : pkt_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pkt_cnt <= '0;
        else     pkt_cnt <= pkt_cnt_nxt;
    end

    assign o_last  = o_valid & (pkt_cnt == CNT_LAST);
    assign o_level = level;

    fifo_rd_skid #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (o_rden),
        .push_data(i_rddata),
        .pop      (hs),
        .flush    (i_flush),
        .valid    (o_valid),
        .data     (o_data),
        .level    (level)
    );

endmodule

// File: tb/tb_my_fifo_reader.sv
// Self-checking bench: a queue-based FIFO environment plus a stream-level
// reference model of in-flight words, delivered count and read enable.
module tb_my_fifo_reader;

    localparam int DATA_W  = 8;
    localparam int PKT_LEN = 4;

    logic              clk;
    logic              rst;
    logic              o_rden;
    logic [DATA_W-1:0] i_rddata;
    logic              i_empty;
    logic              i_flush;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_last;
    logic              i_ready;
    logic [1:0]        o_level;

    my_fifo_reader #(
        .DATA_W (DATA_W),
        .PKT_LEN(PKT_LEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .o_rden  (o_rden),
        .i_rddata(i_rddata),
        .i_empty (i_empty),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .i_ready (i_ready),
        .o_level (o_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment FIFO contents and reference model state.
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] inflight_q[$];
    int                n_delivered;
    bit                rdy_model;

    // Per-cycle observation vs. expectation: {valid,last,level,rden,data}.
    logic [12:0] obs_vec, exp_vec;
    logic        s_valid, s_rden;
    logic [DATA_W-1:0] s_data;
    logic [1:0]  m_level;

    task automatic drive_fifo();
        i_empty  = (fifo_q.size() == 0);
        i_rddata = (fifo_q.size() == 0) ? DATA_W'($urandom) : fifo_q[0];
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    task automatic model_reset();
        inflight_q.delete();
        n_delivered = 0;
        rdy_model   = 1'b0;
    endtask

    // One clock: sample just before the edge, advance model and FIFO just after.
    task automatic tick();
        bit                m_valid, m_last, m_rden, m_hs;
        logic [DATA_W-1:0] m_data, m_word;
        @(negedge clk);
        m_valid = (inflight_q.size() > 0);
        m_data  = m_valid ? inflight_q[0] : '0;
        m_last  = m_valid && ((n_delivered % PKT_LEN) == PKT_LEN - 1);
        m_level = 2'(inflight_q.size());
        m_rden  = rdy_model && (fifo_q.size() > 0) && (inflight_q.size() < 2) && !i_flush;
        m_hs    = m_valid && i_ready;
        m_word  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        s_valid = o_valid;
        s_data  = o_data;
        s_rden  = o_rden;
        obs_vec = {o_valid, o_last, o_level, o_rden, (m_valid ? o_data : 8'h00)};
        exp_vec = {m_valid, m_last, m_level, m_rden, m_data};
        @(posedge clk);
        #1;
        if (i_flush) begin
            inflight_q.delete();
            n_delivered = 0;
        end else begin
            if (m_hs) begin
                void'(inflight_q.pop_front());
                n_delivered++;
            end
            if (m_rden) inflight_q.push_back(m_word);
        end
        if (s_rden && fifo_q.size() > 0) void'(fifo_q.pop_front());
        rdy_model = 1'b1;
        drive_fifo();
    endtask

    task automatic flush_pulse();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_flush = 1'b0; i_ready = 1'b1;
        model_reset();
        push_word(8'h11);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({o_rden, o_valid, o_data, o_last, o_level} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_values: got rden=%0b valid=%0b data=%h last=%0b level=%0d, want all 0",
                     o_rden, o_valid, o_data, o_last, o_level);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_release c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (s_valid !== 1'b1 || s_data !== 8'h11) begin
            n_fail++;
            $display("FAIL first_word: got valid=%0b data=%h, want valid=1 data=11", s_valid, s_data);
        end
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic test_stream();
        int lasts;
        flush_pulse();
        i_ready = 1'b1;
        lasts = 0;
        for (int w = 1; w <= 8; w++) push_word(8'(w));
        for (int c = 0; c < 12; c++) begin
            tick();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL stream c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
            if (obs_vec[12] && obs_vec[11]) lasts++;
        end
        n_checks++;
        if (lasts !== 2) begin
            n_fail++;
            $display("FAIL stream_lasts: got %0d, want 2", lasts);
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] held;
        bit saw_full;
        saw_full = 1'b0;
        flush_pulse();
        for (int w = 0; w < 10; w++) push_word(DATA_W'($urandom));
        for (int c = 0; c < 24; c++) begin
            i_ready = !(c >= 3 && c < 8);
            tick();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL backpressure c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
            if (c == 4) held = s_data;
            if (c == 7) begin
                n_checks++;
                if (s_data !== held || s_rden !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold: got data=%h rden=%0b, want data=%h rden=0", s_data, s_rden, held);
                end
            end
            if (m_level == 2) saw_full = 1'b1;
        end
        i_ready = 1'b1;
        n_checks++;
        if (!saw_full || fifo_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got saw_full=%0b fifo_left=%0d, want 1 and 0", saw_full, fifo_q.size());
        end
    endtask

    task automatic test_underflow();
        flush_pulse();
        i_ready = 1'b1;
        for (int w = 1; w <= 5; w++) push_word(8'(w));
        for (int c = 0; c < 16; c++) begin
            if (c == 9) for (int w = 6; w <= 8; w++) push_word(8'(w));
            tick();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL underflow c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_flush();
        int guard;
        flush_pulse();
        i_ready = 1'b1;
        for (int w = 0; w < 8; w++) push_word(8'h40 + 8'(w));
        guard = 0;
        while (n_delivered < 2 && guard < 20) begin tick(); guard++; end
        i_ready = 1'b0;
        while (inflight_q.size() < 2 && guard < 20) begin tick(); guard++; end
        n_checks++;
        if (guard >= 20 || o_level !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_setup: got level=%0d guard=%0d, want level=2", o_level, guard);
        end
        flush_pulse();
        i_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL flush c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
            if (c == 0 && s_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_valid: got %0b want 0", s_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        flush_pulse();
        i_ready = 1'b1;
        for (int w = 0; w < 10; w++) push_word(8'h80 + 8'(w));
        repeat (4) tick();
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({o_rden, o_valid, o_data, o_last, o_level} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid: got rden=%0b valid=%0b data=%h last=%0b level=%0d, want all 0",
                     o_rden, o_valid, o_data, o_last, o_level);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_mid c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            i_flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) push_word(DATA_W'($urandom));
            tick();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
        i_flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
        drive_fifo();
        test_reset();
        test_stream();
        test_backpressure();
        test_underflow();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
